// File: rtl/qsn_inverse_pipe_if.sv
// Vector stream bundle for the inverse QSN: input side (i_*) and output side (o_*).
// The slave modport is the shifter's view; the master modport is the view of
// whoever feeds and drains it.
interface qsn_inverse_pipe_if #(
    parameter int DWIDTH        = 8,
    parameter int LiftingFactor = 8,
    parameter int SEL           = 3,
    parameter int TWIDTH        = 4
);
    logic              i_valid;
    logic              i_ready;
    logic [DWIDTH-1:0] i_data [LiftingFactor];
    logic [SEL-1:0]    i_shift;
    logic [TWIDTH-1:0] i_tag;
    logic              o_valid;
    logic              o_ready;
    logic [DWIDTH-1:0] o_data [LiftingFactor];
    logic [TWIDTH-1:0] o_tag;
    logic              o_err;

    modport master (
        output i_valid, i_data, i_shift, i_tag, o_ready,
        input  i_ready, o_valid, o_data, o_tag, o_err
    );

    modport slave (
        input  i_valid, i_data, i_shift, i_tag, o_ready,
        output i_ready, o_valid, o_data, o_tag, o_err
    );
endinterface

// File: rtl/qsn_inverse_pipe.sv
// Inverse quasi-cyclic shift network: o_data[i] = i_data[(i - shift) mod Z].
// Three register stages: S0 captures the vector and the inverse amount,
// S1 applies the low half of the log rotator, S2 the high half.
module qsn_inverse_pipe #(
    parameter int DWIDTH        = 8,
    parameter int LiftingFactor = 8,
    parameter int SEL           = 3,
    parameter int TWIDTH        = 4
) (
    input  logic              clk,
    input  logic              rst,
    qsn_inverse_pipe_if.slave bus
);
    localparam int Z = LiftingFactor;
    localparam int L = SEL / 2;
    localparam int H = SEL - L;
    localparam logic [SEL:0] Z_EXT = (SEL+1)'(LiftingFactor);

    logic              s0_valid_reg;
    logic [DWIDTH-1:0] s0_data_reg [Z];
    logic [SEL-1:0]    s0_inv_reg;
    logic [TWIDTH-1:0] s0_tag_reg;
    logic              s0_err_reg;

    logic              s1_valid_reg;
    logic [DWIDTH-1:0] s1_data_reg [Z];
    logic [H-1:0]      s1_inv_hi_reg;
    logic [TWIDTH-1:0] s1_tag_reg;
    logic              s1_err_reg;

    logic              s2_valid_reg;
    logic [DWIDTH-1:0] s2_data_reg [Z];
    logic [TWIDTH-1:0] s2_tag_reg;
    logic              s2_err_reg;

    logic              ready0, ready1, ready2;
    logic              in_err;
    logic [SEL-1:0]    inv_next;
    logic [DWIDTH-1:0] s0_data_next [Z];
    logic [DWIDTH-1:0] lo_rot [Z];
    logic [DWIDTH-1:0] hi_rot [Z];

    // A stage can take new content when it is empty or its successor moves on.
    assign ready2     = ~s2_valid_reg | bus.o_ready;
    assign ready1     = ~s1_valid_reg | ready2;
    assign ready0     = ~s0_valid_reg | ready1;
    assign bus.i_ready = ready0;

    // Left rotation by (Z - shift) mod Z undoes a forward rotation by shift;
    // out-of-range shifts are flagged and their data zeroed.
    always_comb begin
        in_err   = {1'b0, bus.i_shift} >= Z_EXT;
        inv_next = '0;
        if (!in_err && bus.i_shift != '0)
            inv_next = SEL'(Z_EXT - {1'b0, bus.i_shift});
    end

    generate
        for (genvar gi = 0; gi < Z; gi++) begin : g_lane
            assign s0_data_next[gi] = in_err ? '0 : bus.i_data[gi];
            assign bus.o_data[gi]   = s2_data_reg[gi];
        end
    endgenerate

    // Low log stages: bit k rotates left by 2^k mod Z.
    always_comb begin : p_rot_lo
        logic [DWIDTH-1:0] cur [Z];
        logic [DWIDTH-1:0] nxt [Z];
        cur = s0_data_reg;
        nxt = cur;
        for (int k = 0; k < L; k++) begin
            if (s0_inv_reg[k]) begin
                for (int i = 0; i < Z; i++)
                    nxt[i] = cur[(i + ((1 << k) % Z)) % Z];
                cur = nxt;
            end
        end
        lo_rot = cur;
    end

    // High log stages: bit L+k rotates left by 2^(L+k) mod Z.
    always_comb begin : p_rot_hi
        logic [DWIDTH-1:0] cur [Z];
        logic [DWIDTH-1:0] nxt [Z];
        cur = s1_data_reg;
        nxt = cur;
        for (int k = 0; k < H; k++) begin
            if (s1_inv_hi_reg[k]) begin
                for (int i = 0; i < Z; i++)
                    nxt[i] = cur[(i + ((1 << (L + k)) % Z)) % Z];
                cur = nxt;
            end
        end
        hi_rot = cur;
    end

    // Pipeline registers; payload only updates when a valid vector moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg  <= 1'b0;
            s0_data_reg   <= '{default: '0};
            s0_inv_reg    <= '0;
            s0_tag_reg    <= '0;
            s0_err_reg    <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '{default: '0};
            s1_inv_hi_reg <= '0;
            s1_tag_reg    <= '0;
            s1_err_reg    <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_data_reg   <= '{default: '0};
            s2_tag_reg    <= '0;
            s2_err_reg    <= 1'b0;
        end else begin
            if (ready0) begin
                s0_valid_reg <= bus.i_valid;
                if (bus.i_valid) begin
                    s0_data_reg <= s0_data_next;
                    s0_inv_reg  <= inv_next;
                    s0_tag_reg  <= bus.i_tag;
                    s0_err_reg  <= in_err;
                end
            end
            if (ready1) begin
                s1_valid_reg <= s0_valid_reg;
                if (s0_valid_reg) begin
                    s1_data_reg   <= lo_rot;
                    s1_inv_hi_reg <= s0_inv_reg[SEL-1:L];
                    s1_tag_reg    <= s0_tag_reg;
                    s1_err_reg    <= s0_err_reg;
                end
            end
            if (ready2) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= hi_rot;
                    s2_tag_reg  <= s1_tag_reg;
                    s2_err_reg  <= s1_err_reg;
                end
            end
        end
    end

    assign bus.o_valid = s2_valid_reg;
    assign bus.o_tag   = s2_tag_reg;
    assign bus.o_err   = s2_err_reg;
endmodule

// File: tb/tb_qsn_inverse_pipe.sv
// Bench for qsn_inverse_pipe: a Z=8 and a Z=5 instance share one input stream
// (the Z=5 one sees the low five bytes) and are checked against a queue model.
module tb_qsn_inverse_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld = 1'b0;
    logic        ordy = 1'b0;
    logic [63:0] stim = '0;
    logic [2:0]  shift = '0;
    logic [3:0]  tag = '0;
    logic [63:0] oa, ob;

    always #5 clk = ~clk;

    qsn_inverse_pipe_if #(.DWIDTH(8), .LiftingFactor(8), .SEL(3), .TWIDTH(4)) ifa ();
    qsn_inverse_pipe_if #(.DWIDTH(8), .LiftingFactor(5), .SEL(3), .TWIDTH(4)) ifb ();

    qsn_inverse_pipe #(.DWIDTH(8), .LiftingFactor(8), .SEL(3), .TWIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    qsn_inverse_pipe #(.DWIDTH(8), .LiftingFactor(5), .SEL(3), .TWIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.i_valid = vld;
    assign ifa.i_shift = shift;
    assign ifa.i_tag   = tag;
    assign ifa.o_ready = ordy;
    assign ifb.i_valid = vld;
    assign ifb.i_shift = shift;
    assign ifb.i_tag   = tag;
    assign ifb.o_ready = ordy;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_in_a
            assign ifa.i_data[gi] = stim[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 5; gi++) begin : g_in_b
            assign ifb.i_data[gi] = stim[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        oa = '0;
        for (int i = 0; i < 8; i++) oa[8*i +: 8] = ifa.o_data[i];
    end

    always_comb begin
        ob = '0;
        for (int i = 0; i < 5; i++) ob[8*i +: 8] = ifb.o_data[i];
    end

    typedef struct {
        logic [63:0] da;
        logic [63:0] db;
        logic [3:0]  tag;
        logic        ea;
        logic        eb;
    } exp_t;

    exp_t        q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [63:0] snap_a, snap_b;
    logic [3:0]  snap_tag;

    localparam logic [63:0] MASK5 = 64'h0000_00FF_FFFF_FFFF;

    // Reference: inverse rotation of the first z bytes, zero on out-of-range shift.
    function automatic logic [63:0] inv_model(input logic [63:0] v, input int z, input int s);
        logic [63:0] o = '0;
        if (s >= z) return '0;
        for (int i = 0; i < z; i++) o[8*i +: 8] = v[8*((((i - s) % z) + z) % z) +: 8];
        return o;
    endfunction

    // Forward QSN: O[i] = I[(i + s) mod z] over the first z bytes.
    function automatic logic [63:0] fwd_model(input logic [63:0] v, input int z, input int s);
        logic [63:0] o = '0;
        for (int i = 0; i < z; i++) o[8*i +: 8] = v[8*((i + s) % z) +: 8];
        return o;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model, record the input handshake, advance.
    task automatic step(output logic acc);
        exp_t e;
        logic ohs;
        #1;
        acc = vld && ifa.i_ready && !rst;
        ohs = ifa.o_valid && ordy && !rst;
        if (!rst) begin
            chk("i_ready_a", ifa.i_ready, (q.size() < 3) || ordy);
            chk("i_ready_b", ifb.i_ready, (q.size() < 3) || ordy);
            if (q.size() == 0) begin
                chk("no_vector_a", ifa.o_valid, 0);
                chk("no_vector_b", ifb.o_valid, 0);
            end
            if (held) begin
                chk("hold_valid", ifa.o_valid, 1);
                chk("hold_data_a", oa, snap_a);
                chk("hold_data_b", ob, snap_b);
                chk("hold_tag", ifa.o_tag, snap_tag);
            end
            if (ohs && q.size() > 0) begin
                e = q.pop_front();
                n_out++;
                chk("o_valid_b", ifb.o_valid, 1);
                chk("data_a", oa, e.da);
                chk("data_b", ob, e.db);
                chk("tag_a", ifa.o_tag, e.tag);
                chk("tag_b", ifb.o_tag, e.tag);
                chk("err_a", ifa.o_err, e.ea);
                chk("err_b", ifb.o_err, e.eb);
                $display("out tag=%0d a=%h b=%h err_a=%0b err_b=%0b", ifa.o_tag, oa, ob,
                         ifa.o_err, ifb.o_err);
            end
            held = ifa.o_valid && !ordy;
            snap_a = oa;
            snap_b = ob;
            snap_tag = ifa.o_tag;
            if (acc) begin
                e.da  = inv_model(stim, 8, int'(shift));
                e.db  = inv_model(stim, 5, int'(shift));
                e.tag = tag;
                e.ea  = 1'b0;
                e.eb  = shift >= 3'd5;
                q.push_back(e);
            end
        end else begin
            held = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [63:0] d, input logic [2:0] s, input logic [3:0] t);
        logic a = 1'b0;
        stim = d;
        shift = s;
        tag = t;
        vld = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(a);
            if (a) break;
        end
        chk("send_accept", a, 1);
        vld = 1'b0;
    endtask

    task automatic drain();
        logic a;
        vld = 1'b0;
        ordy = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) step(a);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        logic a;
        rst = 1'b1;
        vld = 1'b1;
        stim = rnd64();
        for (int k = 0; k < n; k++) step(a);
        rst = 1'b0;
        vld = 1'b0;
        q.delete();
        held = 1'b0;
    endtask

    initial begin
        logic        a;
        int          lat;
        int          nxt;
        int          out0;
        logic [63:0] orig;

        // Reset with i_valid high: everything cleared, nothing emerges.
        ordy = 1'b1;
        do_reset(2);
        chk("rst_valid_a", ifa.o_valid, 0);
        chk("rst_valid_b", ifb.o_valid, 0);
        chk("rst_data_a", oa, 0);
        chk("rst_data_b", ob, 0);
        chk("rst_tag", ifa.o_tag, 0);
        chk("rst_err_a", ifa.o_err, 0);
        chk("rst_err_b", ifb.o_err, 0);
        for (int k = 0; k < 4; k++) step(a);

        // Z=8, I[i]=i, shift 3, tag 5; latency of three cycles.
        send(64'h0706050403020100, 3'd3, 4'd5);
        q[$].da = 64'h0403020100070605;
        lat = 1;
        while (!ifa.o_valid && lat < 10) begin
            step(a);
            lat++;
        end
        chk("latency", lat, 3);
        drain();

        // Z=5 example and shift 0 identity.
        send(64'h0000000E0D0C0B0A, 3'd4, 4'd1);
        q[$].db = 64'h0000000A0E0D0C0B;
        orig = rnd64();
        send(orig, 3'd0, 4'd2);
        q[$].da = orig;
        q[$].db = orig & MASK5;
        drain();

        // Out-of-range shift for Z=5 between two good neighbours.
        send(rnd64(), 3'd2, 4'd3);
        send(rnd64(), 3'd6, 4'd4);
        q[$].db = '0;
        q[$].eb = 1'b1;
        send(rnd64(), 3'd1, 4'd5);
        drain();

        // Round trip through forward QSN then this block, every shift.
        for (int s = 0; s < 8; s++) begin
            orig = rnd64();
            send(fwd_model(orig, 8, s), 3'(s), 4'(s));
            q[$].da = orig;
        end
        for (int s = 0; s < 5; s++) begin
            orig = rnd64();
            send({orig[63:40], fwd_model(orig, 5, s)[39:0]}, 3'(s), 4'(s + 8));
            q[$].db = orig & MASK5;
        end
        drain();

        // Back-to-back tags 0..9 with o_ready low for cycles 4..9.
        nxt = 0;
        out0 = n_out;
        stim = rnd64();
        shift = 3'($urandom_range(0, 7));
        for (int c = 0; c < 60 && (nxt < 10 || q.size() > 0); c++) begin
            vld = nxt < 10;
            tag = 4'(nxt);
            ordy = !(c >= 4 && c <= 9);
            step(a);
            if (a) begin
                nxt++;
                stim = rnd64();
                shift = 3'($urandom_range(0, 7));
            end
        end
        chk("stream_sent", nxt, 10);
        chk("stream_out", n_out - out0, 10);
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 120; c++) begin
            vld = ($urandom % 4) != 0;
            ordy = ($urandom % 4) != 0;
            stim = rnd64();
            shift = 3'($urandom_range(0, 7));
            tag = 4'($urandom);
            step(a);
        end
        drain();

        // Fill the pipe under backpressure, then reset mid-flight.
        ordy = 1'b0;
        send(rnd64(), 3'd1, 4'd1);
        send(rnd64(), 3'd2, 4'd2);
        send(rnd64(), 3'd3, 4'd3);
        step(a);
        chk("full_i_ready", ifa.i_ready, 0);
        do_reset(1);
        chk("midrst_valid_a", ifa.o_valid, 0);
        chk("midrst_valid_b", ifb.o_valid, 0);
        ordy = 1'b1;
        for (int k = 0; k < 5; k++) step(a);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/qsn_inverse_pipe.md
Name: qsn_inverse_pipe

Overview:
- Inverse quasi-cyclic shift network for the LDPC decoder datapath. It undoes the forward QSN rotation: O[i] = I[(i - shift) mod LiftingFactor].
- Sits on the write-back path between the check-node units and the message memory, so messages rotated on read are stored back in natural order.
- Pipelined logarithmic rotator: 3 register stages, valid/ready handshake, full backpressure, throughput of 1 vector per cycle.

Parameters:
- DWIDTH, configs::DWIDTH, bit width of one message element.
- LiftingFactor, configs::LiftingFactor, number of elements Z per vector. Any integer >= 2; not required to be a power of two.
- SEL, configs::SEL, shift field width. Requires 2^SEL >= LiftingFactor.
- TWIDTH, 4, width of the opaque sideband tag carried alongside each vector.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input vector valid.
- i_ready  output  1  input accepted when i_valid && i_ready.
- i_data  input  DWIDTH x [LiftingFactor]  unpacked input vector.
- i_shift  input  SEL  forward shift amount to undo.
- i_tag  input  TWIDTH  sideband tag, passed through unchanged.
- o_valid  output  1  output vector valid.
- o_ready  input  1  downstream accepts when o_valid && o_ready.
- o_data  output  DWIDTH x [LiftingFactor]  de-rotated vector.
- o_tag  output  TWIDTH  tag of the vector on o_data.
- o_err  output  1  the vector on o_data had i_shift >= LiftingFactor.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high, named rst.
- Reset values: all stage valid bits = 0, data/tag registers = 0, err bits = 0. Hence o_valid=0, o_data all zero, o_tag=0, o_err=0 in the cycle after rst is sampled high.
- A reset mid-operation drops all in-flight vectors. No output handshake occurs for them.
- Stage S0 (capture): registers i_data, i_tag and the inverse amount inv = (LiftingFactor - i_shift) mod LiftingFactor. So i_shift=0 gives inv=0.
  - If i_shift >= LiftingFactor: err=1, inv=0, and the data is forced to all zero.
- Stage S1: rotates the S0 data left by inv[L-1:0], where L = SEL/2 rounded down. Rotation uses log stages of 2^k, each applied mod LiftingFactor. Left rotation by r means out[i] = in[(i + r) mod Z].
- Stage S2: rotates left by inv[SEL-1:L]·2^L, applied mod LiftingFactor. Drives o_data, o_tag, o_err and o_valid.
- Net result: o_data[i] = i_data[(i - shift) mod Z]. Composing with the forward QSN (O[i] = I[(i + shift) mod Z]) at the same shift is the identity.
- Handshake:
  - ready_k = ~valid_k | ready_{k+1}, with ready_3 = o_ready, and i_ready = ready_0.
  - i_ready is combinational from o_ready and the stage valid bits; there are no combinational paths from i_valid to the outputs.
  - A stage loads when its own ready is high. Its valid bit takes the upstream valid; bubbles collapse.
  - While o_valid=1 and o_ready=0: o_data, o_tag and o_err hold stable, and o_valid stays 1.
- Latency: exactly 3 cycles from input handshake to o_valid when o_ready is held high. Sustained 1 vector per cycle.
- Capacity: 3 vectors in flight. With o_ready low, i_ready goes low only after 3 accepted vectors fill S0–S2, or fewer if already occupied.
- Simultaneous events: an output handshake and an input handshake in the same cycle with a full pipe shifts all stages. Nothing is lost or duplicated.
- Ordering: strictly in order. Tags emerge in acceptance order.
- Error handling: o_err is per vector. It has no sticky state and does not stall the pipe.

Test Plan:
- Reset values and basic de-rotation:
  - Reset: assert rst 2 cycles with i_valid=1 -> o_valid=0, o_data zeros, o_tag=0, o_err=0; no vector emerges.
  - Z=8, DWIDTH=8, I[i]=i, shift=3, tag=5, o_ready=1 -> 3 cycles later o_data = {5,6,7,0,1,2,3,4} (index 0 first), o_tag=5, o_err=0.
- Non-power-of-two Z and identity:
  - Z=5, I={10,11,12,13,14}, shift=4 -> o_data={11,12,13,14,10}.
  - shift=0 -> o_data equals I.
- Round trip: random vectors through the forward QSN at shift s, then this block at shift s, for all s in 0..Z-1 -> output equals the original every time.
- Backpressure and ordering:
  - Stream tags 0..9 back-to-back with o_ready low for cycles 4–9 -> i_ready drops after the 3rd buffered vector.
  - o_data held stable while stalled; all 10 vectors emerge in tag order with no loss or duplication.
- Error and mid-operation reset:
  - Z=5, shift=6 -> that vector emerges with o_err=1 and data zero. Neighbouring vectors are correct with o_err=0.
  - Reset with the pipe full -> o_valid=0 the next cycle.
